// File: rtl/wptr_full.sv
// Write-side pointer and full/level flag generator for a Gray-pointer async FIFO.
// Consumes the read pointer already synchronised into the write clock domain.
module wptr_full #(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14
) (
    input  logic              i_wClk,
    input  logic              i_wRst_n,
    input  logic              i_wInc,
    input  logic [ADDR_W:0]   i_wq2RPtr,
    output logic [ADDR_W-1:0] o_wAddr,
    output logic [ADDR_W:0]   o_wPtr,
    output logic              o_wFull,
    output logic              o_wAlmostFull,
    output logic [ADDR_W:0]   o_wLevel,
    output logic              o_wOverflow
);

    localparam logic [ADDR_W:0] AF_THRESH = AF_LEVEL[ADDR_W:0];

    logic [ADDR_W:0] w_bin_q, w_bin_d;
    logic [ADDR_W:0] w_gray_q, w_gray_d;
    logic [ADDR_W:0] level_q, level_d;
    logic            full_q, full_d;
    logic            afull_q, afull_d;
    logic            overflow_q, overflow_d;

    logic            w_en;
    logic [ADDR_W:0] r_bin;
    logic [ADDR_W:0] r_gray_full;

    always_comb begin
        r_bin = '0;
        r_bin[ADDR_W] = i_wq2RPtr[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            r_bin[i] = r_bin[i+1] ^ i_wq2RPtr[i];
        end
    end

    // Full when our next Gray pointer equals the read pointer with its two MSBs inverted,
    // i.e. the binary pointers differ by exactly DEPTH.
    assign r_gray_full = {~i_wq2RPtr[ADDR_W:ADDR_W-1], i_wq2RPtr[ADDR_W-2:0]};

    always_comb begin
        w_en       = i_wInc & ~full_q;
        w_bin_d    = w_bin_q + {{ADDR_W{1'b0}}, w_en};
        w_gray_d   = (w_bin_d >> 1) ^ w_bin_d;
        level_d    = w_bin_d - r_bin;
        full_d     = (w_gray_d == r_gray_full);
        afull_d    = (level_d >= AF_THRESH);
        overflow_d = i_wInc & full_q;
    end

    always_ff @(posedge i_wClk) begin
        if (!i_wRst_n) begin
            w_bin_q    <= '0;
            w_gray_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            w_bin_q    <= w_bin_d;
            w_gray_q   <= w_gray_d;
            level_q    <= level_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_wAddr       = w_bin_q[ADDR_W-1:0];
    assign o_wPtr        = w_gray_q;
    assign o_wFull       = full_q;
    assign o_wAlmostFull = afull_q;
    assign o_wLevel      = level_q;
    assign o_wOverflow   = overflow_q;

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full: directed scenarios plus random traffic against a counting model.
module tb_wptr_full;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int NPTR  = 2 * DEPTH;
    localparam int AF    = 14;

    logic          clk = 1'b0;
    logic          i_wRst_n = 1'b0;
    logic          i_wInc = 1'b0;
    logic [AW:0]   i_wq2RPtr = '0;
    logic [AW-1:0] o_wAddr;
    logic [AW:0]   o_wPtr;
    logic          o_wFull;
    logic          o_wAlmostFull;
    logic [AW:0]   o_wLevel;
    logic          o_wOverflow;

    int checks = 0;
    int errors = 0;

    // Reference state: write count modulo 2*DEPTH and the registered flags it implies.
    int m_wbin = 0;
    int m_level = 0;
    int m_full = 0;
    int m_af = 0;
    int m_ovf = 0;
    int r_model = 0;

    wptr_full #(.ADDR_W(AW), .AF_LEVEL(AF)) dut (
        .i_wClk       (clk),
        .i_wRst_n     (i_wRst_n),
        .i_wInc       (i_wInc),
        .i_wq2RPtr    (i_wq2RPtr),
        .o_wAddr      (o_wAddr),
        .o_wPtr       (o_wPtr),
        .o_wFull      (o_wFull),
        .o_wAlmostFull(o_wAlmostFull),
        .o_wLevel     (o_wLevel),
        .o_wOverflow  (o_wOverflow)
    );

    always #5 clk = ~clk;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    // Decode by table search over all pointer values.
    function automatic int g2b(input logic [AW:0] g);
        for (int b = 0; b < NPTR; b++) begin
            if (gray(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic inc, input logic [AW:0] rptr);
        logic [AW:0] prev;
        int en;
        int nb;
        int lvl;
        prev      = o_wPtr;
        i_wRst_n  = rst_n;
        i_wInc    = inc;
        i_wq2RPtr = rptr;
        @(posedge clk);
        en = 0;
        if (!rst_n) begin
            m_wbin = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            en      = (inc && m_full == 0) ? 1 : 0;
            nb      = (m_wbin + en) % NPTR;
            lvl     = (nb - g2b(rptr) + NPTR) % NPTR;
            m_ovf   = (inc && m_full != 0) ? 1 : 0;
            m_full  = (lvl == DEPTH) ? 1 : 0;
            m_af    = (lvl >= AF) ? 1 : 0;
            m_level = lvl;
            m_wbin  = nb;
        end
        #1;
        check("addr",     32'(o_wAddr),       32'(m_wbin % DEPTH));
        check("ptr",      32'(o_wPtr),        32'(gray(m_wbin)));
        check("full",     32'(o_wFull),       32'(m_full));
        check("afull",    32'(o_wAlmostFull), 32'(m_af));
        check("level",    32'(o_wLevel),      32'(m_level));
        check("overflow", 32'(o_wOverflow),   32'(m_ovf));
        if (rst_n) check("gray_one_bit", 32'($countones(o_wPtr ^ prev)), 32'(en));
    endtask

    initial begin
        // Reset held with write requests pending
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
        check("rst_ptr", 32'(o_wPtr), 32'd0);

        // Fill from empty
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_addr_pre", 32'(o_wAddr), 32'(i));
            step(1'b1, 1'b1, '0);
            check("fill_af", 32'(o_wAlmostFull), (i + 1 >= AF) ? 32'd1 : 32'd0);
        end
        check("fill_full",  32'(o_wFull),  32'd1);
        check("fill_level", 32'(o_wLevel), 32'd16);
        check("fill_ptr",   32'(o_wPtr),   32'b11000);

        // Overflow while full
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, '0);
            check("ovf_pulse", 32'(o_wOverflow), 32'd1);
            check("ovf_ptr",   32'(o_wPtr),      32'b11000);
            check("ovf_addr",  32'(o_wAddr),     32'd0);
        end

        // Drain release: read pointer reaches 1
        step(1'b1, 1'b0, 5'b00001);
        check("drain_full",  32'(o_wFull),     32'd0);
        check("drain_level", 32'(o_wLevel),    32'd15);
        check("drain_ovf",   32'(o_wOverflow), 32'd0);
        check("drain_addr",  32'(o_wAddr),     32'd0);

        // Write and read advance on the same edge at level 15
        step(1'b1, 1'b1, gray(2));
        check("simul_level", 32'(o_wLevel), 32'd15);
        check("simul_full",  32'(o_wFull),  32'd0);
        check("simul_addr",  32'(o_wAddr),  32'd1);

        // Wrap-around with the read pointer trailing by three
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, gray((m_wbin - 2 + NPTR) % NPTR));
            check("wrap_level", 32'(o_wLevel), 32'd3);
            check("wrap_full",  32'(o_wFull),  32'd0);
        end

        // Random traffic with a legal read side and occasional reset
        r_model = g2b(i_wq2RPtr);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                r_model = 0;
                step(1'b0, 1'($urandom_range(0, 1)), '0);
            end else begin
                if ($urandom_range(0, 2) == 0 && ((m_wbin - r_model + NPTR) % NPTR) > 0)
                    r_model = (r_model + 1) % NPTR;
                step(1'b1, 1'($urandom_range(0, 3) != 0), gray(r_model));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
